// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam int MEM_WAIT_DEFAULT = 1;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port memory with a fixed read wait.
// Macro ARB_RR_EN: simultaneous requests alternate; otherwise data wins over fetch.
//
// state | meaning
// IDLE  | no owner, sampling if_req / d_req
// ISSUE | memory access driven from the latched request
// WAIT  | read wait cycles, rdata captured on the last one
// DONE  | owner's done pulse, returns to IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEFAULT,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  output logic              if_grant,
  output logic              d_grant,
  output logic              if_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  state_t     state;
  req_id_t    owner;
  logic       we_q;
  logic [2:0] wait_cnt;
  logic       d_win;

`ifdef ARB_RR_EN
  req_id_t last_served;
  assign d_win = d_req && (!if_req || last_served == REQ_IF);
`else
  assign d_win = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner     <= REQ_IF;
      we_q      <= 1'b0;
      wait_cnt  <= 3'd0;
      if_grant  <= 1'b0;
      d_grant   <= 1'b0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
`ifdef ARB_RR_EN
      last_served <= REQ_IF;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_req || d_req) begin
            state     <= S_ISSUE;
            busy      <= 1'b1;
            owner     <= d_win ? REQ_D : REQ_IF;
            if_grant  <= !d_win;
            d_grant   <= d_win;
            mem_addr  <= d_win ? d_addr : if_addr;
            mem_wdata <= d_win ? d_wdata : '0;
            we_q      <= d_win && d_we;
            mem_read  <= !(d_win && d_we);
            mem_write <= d_win && d_we;
`ifdef ARB_RR_EN
            last_served <= d_win ? REQ_D : REQ_IF;
`endif
          end
        end
        S_ISSUE: begin
          if (we_q || MEM_WAIT == 0) begin
            state     <= S_DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!we_q) rdata <= mem_rdata;
            if_done   <= (owner == REQ_IF);
            d_done    <= (owner == REQ_D);
          end else begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state    <= S_DONE;
            mem_read <= 1'b0;
            rdata    <= mem_rdata;
            if_done  <= (owner == REQ_IF);
            d_done   <= (owner == REQ_D);
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          if_grant <= 1'b0;
          d_grant  <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: main instance MEM_WAIT=1, plus MEM_WAIT=0 and 3 for latency.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] K = 32'h8C010044;  // memory model: rdata = addr ^ K

  logic clk = 1'b0;
  logic reset;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  always #5 clk = ~clk;

  logic if_grant_a, d_grant_a, if_done_a, d_done_a, mem_read_a, mem_write_a, busy_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic if_grant_z, d_grant_z, if_done_z, d_done_z, mem_read_z, mem_write_z, busy_z;
  logic [31:0] rdata_z, mem_addr_z, mem_wdata_z, mem_rdata_z;
  logic if_grant_t, d_grant_t, if_done_t, d_done_t, mem_read_t, mem_write_t, busy_t;
  logic [31:0] rdata_t, mem_addr_t, mem_wdata_t, mem_rdata_t;

  assign mem_rdata_a = mem_addr_a ^ K;
  assign mem_rdata_z = mem_addr_z ^ K;
  assign mem_rdata_t = mem_addr_t ^ K;

  mem_arbiter #(.MEM_WAIT(1), .ADDR_W(32), .DATA_W(32)) u_a (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .d_req(d_req),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .if_grant(if_grant_a),
    .d_grant(d_grant_a), .if_done(if_done_a), .d_done(d_done_a), .rdata(rdata_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_rdata(mem_rdata_a), .busy(busy_a));

  mem_arbiter #(.MEM_WAIT(0), .ADDR_W(32), .DATA_W(32)) u_z (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .d_req(d_req),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .if_grant(if_grant_z),
    .d_grant(d_grant_z), .if_done(if_done_z), .d_done(d_done_z), .rdata(rdata_z),
    .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z), .mem_read(mem_read_z),
    .mem_write(mem_write_z), .mem_rdata(mem_rdata_z), .busy(busy_z));

  mem_arbiter #(.MEM_WAIT(3), .ADDR_W(32), .DATA_W(32)) u_t (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .d_req(d_req),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .if_grant(if_grant_t),
    .d_grant(d_grant_t), .if_done(if_done_t), .d_done(d_done_t), .rdata(rdata_t),
    .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_read(mem_read_t),
    .mem_write(mem_write_t), .mem_rdata(mem_rdata_t), .busy(busy_t));

  typedef struct {
    int          unit;   // 0: MEM_WAIT=1, 1: MEM_WAIT=0, 2: MEM_WAIT=3
    logic        is_d;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd_model;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if (busy_a !== 1'b0 || if_grant_a !== 1'b0 || d_grant_a !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got busy=%b ig=%b dg=%b want 0", busy_a, if_grant_a, d_grant_a);
    end
    total++;
    if (mem_read_a !== 1'b0 || mem_write_a !== 1'b0 || if_done_a !== 1'b0 || d_done_a !== 1'b0) begin
      bad++; $display("FAIL reset_mem got rd=%b wr=%b idn=%b ddn=%b want 0",
                      mem_read_a, mem_write_a, if_done_a, d_done_a);
    end
    total++;
    if (mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0 || rdata_a !== 32'h0) begin
      bad++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", mem_addr_a, mem_wdata_a, rdata_a);
    end
    reset = 1'b1;
    rd_model = 32'h0;
    idle(2);
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_release_idle got busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_fetch_read();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h40;
    rd_model = 32'h40 ^ K;
    sb.push_back('{0, 1'b0, rd_model, 3});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (mem_read_a !== 1'((k == 1) || (k == 2))) begin
        bad++; $display("FAIL fetch_mem_read cyc=%0d got=%b want=%b", k, mem_read_a, (k == 1) || (k == 2));
      end
      if (if_done_a || d_done_a) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL fetch_extra_done cyc=%0d got done want none", k);
        end else begin
          e = sb.pop_front();
          if (d_done_a !== e.is_d || k != e.cyc || rdata_a !== e.rdata) begin
            bad++; $display("FAIL fetch_done got d=%b cyc=%0d rdata=%h want d=%b cyc=%0d rdata=%h",
                            d_done_a, k, rdata_a, e.is_d, e.cyc, e.rdata);
          end
        end
        if_req = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL fetch_timeout got pending=%0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_write();
    exp_t e;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    sb.push_back('{0, 1'b1, rd_model, 2});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (mem_write_a !== 1'(k == 1) || mem_read_a !== 1'b0) begin
        bad++; $display("FAIL write_strobes cyc=%0d got wr=%b rd=%b want wr=%b rd=0", k, mem_write_a, mem_read_a, k == 1);
      end
      if (k == 1) begin
        total++;
        if (mem_addr_a !== 32'h100 || mem_wdata_a !== 32'hDEADBEEF || d_grant_a !== 1'b1) begin
          bad++; $display("FAIL write_bus got addr=%h wdata=%h dg=%b want 00000100 deadbeef 1",
                          mem_addr_a, mem_wdata_a, d_grant_a);
        end
      end
      if (if_done_a || d_done_a) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL write_extra_done cyc=%0d got done want none", k);
        end else begin
          e = sb.pop_front();
          if (d_done_a !== e.is_d || k != e.cyc || rdata_a !== e.rdata) begin
            bad++; $display("FAIL write_done got d=%b cyc=%0d rdata=%h want d=%b cyc=%0d rdata=%h",
                            d_done_a, k, rdata_a, e.is_d, e.cyc, e.rdata);
          end
        end
        d_req = 1'b0; d_we = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL write_timeout got pending=%0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_arbitration();
    exp_t e;
    logic first_d;
`ifdef ARB_RR_EN
    first_d = 1'b0;  // previous grant went to data
`else
    first_d = 1'b1;
`endif
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    sb.push_back('{0, first_d, (first_d ? 32'h200 : 32'h80) ^ K, 3});
    sb.push_back('{0, !first_d, (first_d ? 32'h80 : 32'h200) ^ K, 7});
    rd_model = (first_d ? 32'h80 : 32'h200) ^ K;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if ((if_grant_a && d_grant_a) || (mem_read_a && mem_write_a)) begin
        bad++; $display("FAIL arb_exclusive cyc=%0d got ig=%b dg=%b rd=%b wr=%b want no overlap",
                        k, if_grant_a, d_grant_a, mem_read_a, mem_write_a);
      end
      if (k == 1) begin
        total++;
        if (d_grant_a !== first_d) begin
          bad++; $display("FAIL arb_first_grant got dg=%b want %b", d_grant_a, first_d);
        end
      end
      if (if_done_a || d_done_a) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL arb_extra_done cyc=%0d got done want none", k);
        end else begin
          e = sb.pop_front();
          if (d_done_a !== e.is_d || k != e.cyc || rdata_a !== e.rdata) begin
            bad++; $display("FAIL arb_done got d=%b cyc=%0d rdata=%h want d=%b cyc=%0d rdata=%h",
                            d_done_a, k, rdata_a, e.is_d, e.cyc, e.rdata);
          end
        end
        if (if_done_a) if_req = 1'b0;
        if (d_done_a) d_req = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL arb_timeout got pending=%0d want 0", sb.size()); sb.delete();
    end
  endtask

  // Request dropped and address changed right after the grant, on all three wait settings.
  task automatic test_latch_latency();
    logic dn[3];
    logic rd[3];
    logic [31:0] ad[3];
    logic [31:0] rv[3];
    int idx;
    if_req = 1'b1; if_addr = 32'hC0;
    sb.push_back('{0, 1'b0, 32'hC0 ^ K, 3});
    sb.push_back('{1, 1'b0, 32'hC0 ^ K, 2});
    sb.push_back('{2, 1'b0, 32'hC0 ^ K, 5});
    rd_model = 32'hC0 ^ K;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin if_addr = 32'hFFC; if_req = 1'b0; end
      dn = '{if_done_a, if_done_z, if_done_t};
      rd = '{mem_read_a, mem_read_z, mem_read_t};
      ad = '{mem_addr_a, mem_addr_z, mem_addr_t};
      rv = '{rdata_a, rdata_z, rdata_t};
      for (int u = 0; u < 3; u++) begin
        if (rd[u]) begin
          total++;
          if (ad[u] !== 32'hC0) begin
            bad++; $display("FAIL latch_addr unit=%0d cyc=%0d got=%h want=000000c0", u, k, ad[u]);
          end
        end
        if (dn[u]) begin
          total++;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].unit == u) idx = i;
          if (idx < 0) begin
            bad++; $display("FAIL latency_extra_done unit=%0d cyc=%0d got done want none", u, k);
          end else begin
            if (k != sb[idx].cyc || rv[u] !== sb[idx].rdata) begin
              bad++; $display("FAIL latency_done unit=%0d got cyc=%0d rdata=%h want cyc=%0d rdata=%h",
                              u, k, rv[u], sb[idx].cyc, sb[idx].rdata);
            end
            sb.delete(idx);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL latency_timeout got pending=%0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h44;
    idle(2);
    total++;
    if (mem_read_a !== 1'b1 || busy_a !== 1'b1) begin
      bad++; $display("FAIL rstmid_in_wait got rd=%b busy=%b want 1 1", mem_read_a, busy_a);
    end
    #1 reset = 1'b0; if_req = 1'b0;
    #1;
    total++;
    if (mem_read_a !== 1'b0 || busy_a !== 1'b0 || if_grant_a !== 1'b0) begin
      bad++; $display("FAIL rstmid_immediate got rd=%b busy=%b ig=%b want 0 0 0", mem_read_a, busy_a, if_grant_a);
    end
    rd_model = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (if_done_a !== 1'b0 || d_done_a !== 1'b0 || rdata_a !== rd_model) begin
        bad++; $display("FAIL rstmid_no_done got idn=%b ddn=%b rdata=%h want 0 0 %h", if_done_a, d_done_a, rdata_a, rd_model);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h48;
    rd_model = 32'h48 ^ K;
    sb.push_back('{0, 1'b0, rd_model, 3});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (if_done_a || d_done_a) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rstmid_extra_done cyc=%0d got done want none", k);
        end else begin
          e = sb.pop_front();
          if (d_done_a !== e.is_d || k != e.cyc || rdata_a !== e.rdata) begin
            bad++; $display("FAIL rstmid_done got d=%b cyc=%0d rdata=%h want d=%b cyc=%0d rdata=%h",
                            d_done_a, k, rdata_a, e.is_d, e.cyc, e.rdata);
          end
        end
        if_req = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL rstmid_timeout got pending=%0d want 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    idle(2);
    test_reset();
    test_fetch_read();
    idle(3);
    test_write();
    idle(3);
    test_arbitration();
    idle(3);
    test_latch_latency();
    idle(3);
    test_reset_mid();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
